// File: rtl/fp_div_seq.sv
// Sequential binary32 divider: restoring radix-2 mantissa division, one quotient
// bit per clock, fixed 26-cycle latency, truncating, subnormals flushed to zero.
module fp_div_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  output logic        busy,
  output logic        done,
  output logic [31:0] Q,
  output logic        EX
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_NORM = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [25:0]       rem_q, rem_d;
  logic [24:0]       quot_q, quot_d;
  logic [23:0]       m2_q, m2_d;
  logic signed [9:0] exp_q, exp_d;
  logic              sign_q, sign_d;
  logic              nan_in_q, nan_in_d;
  logic              z1_q, z1_d;
  logic              z2_q, z2_d;
  logic [31:0]       res_q, res_d;
  logic              ex_q, ex_d;
  logic              done_q, done_d;

  logic signed [9:0] norm_exp;
  logic [22:0]       norm_frac;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    m2_d      = m2_q;
    exp_d     = exp_q;
    sign_d    = sign_q;
    nan_in_d  = nan_in_q;
    z1_d      = z1_q;
    z2_d      = z2_q;
    res_d     = res_q;
    ex_d      = ex_q;
    done_d    = 1'b0;

    // Quotient lies in [2^23, 2^25): bit 24 selects the one-place normalisation.
    if (quot_q[24]) begin
      norm_exp  = exp_q;
      norm_frac = quot_q[23:1];
    end else begin
      norm_exp  = exp_q - 10'sd1;
      norm_frac = quot_q[22:0];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sign_d   = D1[31] ^ D2[31];
          exp_d    = $signed({2'b00, D1[30:23]}) - $signed({2'b00, D2[30:23]}) + 10'sd127;
          m2_d     = {1'b1, D2[22:0]};
          rem_d    = {2'b01, D1[22:0]};
          quot_d   = '0;
          cnt_d    = 5'd24;
          nan_in_d = (D1[30:23] == 8'hFF) || (D2[30:23] == 8'hFF);
          z1_d     = (D1[30:23] == 8'h00);
          z2_d     = (D2[30:23] == 8'h00);
          state_d  = S_DIV;
        end
      end
      S_DIV: begin
        if (rem_q >= {2'b00, m2_q}) begin
          rem_d  = (rem_q - {2'b00, m2_q}) << 1;
          quot_d = {quot_q[23:0], 1'b1};
        end else begin
          rem_d  = rem_q << 1;
          quot_d = {quot_q[23:0], 1'b0};
        end
        if (cnt_q == 5'd0) begin
          state_d = S_NORM;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_NORM: begin
        // Special operands override the computed quotient, first match wins.
        if (nan_in_q || (z1_q && z2_q)) begin
          res_d = 32'h7FC0_0000;
          ex_d  = 1'b1;
        end else if (z2_q) begin
          res_d = {sign_q, 8'hFF, 23'h0};
          ex_d  = 1'b1;
        end else if (z1_q) begin
          res_d = 32'h0000_0000;
          ex_d  = 1'b0;
        end else if (norm_exp >= 10'sd255) begin
          res_d = {sign_q, 8'hFF, 23'h0};
          ex_d  = 1'b1;
        end else if (norm_exp <= 10'sd0) begin
          res_d = 32'h0000_0000;
          ex_d  = 1'b1;
        end else begin
          res_d = {sign_q, norm_exp[7:0], norm_frac};
          ex_d  = 1'b0;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      m2_q     <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      nan_in_q <= 1'b0;
      z1_q     <= 1'b0;
      z2_q     <= 1'b0;
      res_q    <= '0;
      ex_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      m2_q     <= m2_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      nan_in_q <= nan_in_d;
      z1_q     <= z1_d;
      z2_q     <= z2_d;
      res_q    <= res_d;
      ex_q     <= ex_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign Q    = res_q;
  assign EX   = ex_q;

endmodule
